// File: rtl/spart_pkg.sv
// Shared constants, FSM encoding and helpers
// for the SPART nibble-packet transmitter.
package spart_pkg;

  localparam logic [7:0] BAUD_DIV_DEF = 8'h50;
  localparam int         OVERSAMPLE   = 16;
  localparam logic [3:0] OS_LAST      = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] STOP_BIT     = 4'd9;

  localparam logic [7:0] TERM_BYTE = 8'hF0;
  localparam logic [3:0] LAST_IDX  = 4'd14;

  localparam logic [2:0] A_N0  = 3'd1;
  localparam logic [2:0] A_N1  = 3'd2;
  localparam logic [2:0] A_N5  = 3'd3;
  localparam logic [2:0] A_N9  = 3'd4;
  localparam logic [2:0] A_N13 = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } state_e;

  // A word write fills four consecutive nibbles
  // with the top nibble landing in the lowest one.
  function automatic logic [15:0] nib_order(
    input logic [15:0] d
  );
    return {d[3:0], d[7:4], d[11:8], d[15:12]};
  endfunction

endpackage

// File: rtl/uart_tx_shift.sv
// UART frame shifter: start, 8 data LSB first, stop.
// In: clk, rst_n, tick, load, tx_byte. Out: txd, tx_busy.
module uart_tx_shift
  import spart_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] tx_byte,
  output logic       txd,
  output logic       tx_busy
);

  logic [9:0] sh_q, sh_d;
  logic [3:0] os_q, os_d;
  logic [3:0] bit_q, bit_d;
  logic       armed_q, armed_d;
  logic       act_q, act_d;
  logic       txd_q, txd_d;

  assign txd     = txd_q;
  assign tx_busy = armed_q | act_q;

  always_comb begin
    sh_d    = sh_q;
    os_d    = os_q;
    bit_d   = bit_q;
    armed_d = armed_q;
    act_d   = act_q;
    txd_d   = txd_q;
    if (load && !armed_q && !act_q) begin
      // Frame is staged; the line stays idle
      // until the next tick so bit edges align.
      sh_d    = {1'b1, tx_byte, 1'b0};
      armed_d = 1'b1;
    end else if (tick && armed_q) begin
      txd_d   = sh_q[0];
      sh_d    = {1'b1, sh_q[9:1]};
      armed_d = 1'b0;
      act_d   = 1'b1;
      os_d    = '0;
      bit_d   = '0;
    end else if (tick && act_q) begin
      if (os_q == OS_LAST) begin
        os_d = '0;
        if (bit_q == STOP_BIT) begin
          act_d = 1'b0;
          txd_d = 1'b1;
        end else begin
          txd_d = sh_q[0];
          sh_d  = {1'b1, sh_q[9:1]};
          bit_d = bit_q + 4'd1;
        end
      end else begin
        os_d = os_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q    <= '1;
      os_q    <= '0;
      bit_q   <= '0;
      armed_q <= 1'b0;
      act_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      sh_q    <= sh_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      armed_q <= armed_d;
      act_q   <= act_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: rtl/spart_packet_tx.sv
// SPART packet transmitter: 15 nibbles + terminator.
// In: clk, rst_n, wr_en, addr, data_in, start. Out: busy, done, txd.
module spart_packet_tx
  import spart_pkg::*;
#(
  parameter logic [7:0] BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [2:0]  addr,
  input  logic [15:0] data_in,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        txd
);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [59:0] nib_q, nib_d;
  logic [7:0]  baud_q, baud_d;

  logic        tick;
  logic        load;
  logic        tx_busy;
  logic        wr_ok;
  logic [63:0] nib_all;
  logic [3:0]  cur_nib;
  logic [7:0]  tx_byte;

  assign tick   = (baud_q == 8'd0);
  assign baud_d = tick ? BAUD_DIV : baud_q - 8'd1;

  assign wr_ok = wr_en && (state_q == ST_IDLE);

  always_comb begin
    nib_d = nib_q;
    if (wr_ok) begin
      unique case (1'b1)
        (addr == A_N0):  nib_d[3:0]   = data_in[3:0];
        (addr == A_N1):  nib_d[19:4]  = nib_order(data_in);
        (addr == A_N5):  nib_d[35:20] = nib_order(data_in);
        (addr == A_N9):  nib_d[51:36] = nib_order(data_in);
        (addr == A_N13): nib_d[59:52] = {data_in[3:0], data_in[7:4]};
        default: ;
      endcase
    end
  end

  // Padding keeps the index in range when idx is 15.
  assign nib_all = {4'h0, nib_q};
  assign cur_nib = nib_all[{idx_q, 2'b00} +: 4];
  assign tx_byte = (idx_q > LAST_IDX) ? TERM_BYTE
                                      : {idx_q, cur_nib};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = 4'd0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load    = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_busy) begin
          if (idx_q > LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_LOAD) ||
                (state_q == ST_SEND);
  assign done = (state_q == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      nib_q   <= '0;
      baud_q  <= BAUD_DIV;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nib_q   <= nib_d;
      baud_q  <= baud_d;
    end
  end

  uart_tx_shift u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .load    (load),
    .tx_byte (tx_byte),
    .txd     (txd),
    .tx_busy (tx_busy)
  );

endmodule
